// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE convolution sequencer: FSM state encoding and the
// command word handed to the PE datapath.
package pe_ctrl_pkg;

  localparam int PE_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_DONE
  } seq_state_t;

  typedef struct packed {
    logic [PE_ADDR_WIDTH-1:0] filter_addr;
    logic [PE_ADDR_WIDTH-1:0] ifmap_addr;
    logic                     add_sel;
    logic                     split_sel;
    logic                     acc_clear;
  } pe_cmd_t;

endpackage

// File: rtl/pe_conv_sequencer_if.sv
// Start/command/done channels between the array scheduler, the sequencer and
// the PE datapath. "master" is the sequencer side, "slave" its environment.
interface pe_conv_sequencer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start_valid;
  logic                  start_ready;
  logic                  abort;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_filter_addr;
  logic [ADDR_WIDTH-1:0] cmd_ifmap_addr;
  logic                  cmd_add_sel;
  logic                  cmd_split_sel;
  logic                  cmd_acc_clear;
  logic                  done_valid;
  logic                  done_ready;
  logic                  busy;

  modport master (
    input  start_valid, abort, cmd_ready, done_ready,
    output start_ready, cmd_valid, cmd_filter_addr, cmd_ifmap_addr,
           cmd_add_sel, cmd_split_sel, cmd_acc_clear, done_valid, busy
  );

  modport slave (
    output start_valid, abort, cmd_ready, done_ready,
    input  start_ready, cmd_valid, cmd_filter_addr, cmd_ifmap_addr,
           cmd_add_sel, cmd_split_sel, cmd_acc_clear, done_valid, busy
  );
endinterface

// File: rtl/pe_tap_counter.sv
// Nested (output position o, filter tap f) counter. o_o/f_o and the tap flags
// look ahead to the position held after this edge; last_cmd_o is for the current one.
module pe_tap_counter #(
  parameter int DEPTH_F    = 3,
  parameter int DEPTH_I    = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic                  clear_i,
  output logic [ADDR_WIDTH-1:0] o_o,
  output logic [ADDR_WIDTH-1:0] f_o,
  output logic                  first_tap_o,
  output logic                  last_tap_o,
  output logic                  last_cmd_o
);
  localparam int N_OUT = DEPTH_I - DEPTH_F + 1;
  localparam logic [ADDR_WIDTH-1:0] F_LAST = ADDR_WIDTH'(DEPTH_F - 1);
  localparam logic [ADDR_WIDTH-1:0] O_LAST = ADDR_WIDTH'(N_OUT - 1);

  logic [ADDR_WIDTH-1:0] o_q, o_d, f_q, f_d;

  assign last_cmd_o = (f_q == F_LAST) && (o_q == O_LAST);

  // Wrapping to (0,0) after the final command keeps the counter idle-clean.
  always_comb begin
    o_d = o_q;
    f_d = f_q;
    if (clear_i || load_i) begin
      o_d = '0;
      f_d = '0;
    end else if (advance_i) begin
      if (last_cmd_o) begin
        o_d = '0;
        f_d = '0;
      end else if (f_q == F_LAST) begin
        o_d = o_q + 1'b1;
        f_d = '0;
      end else begin
        f_d = f_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
      f_q <= '0;
    end else begin
      o_q <= o_d;
      f_q <= f_d;
    end
  end

  assign o_o         = o_d;
  assign f_o         = f_d;
  assign first_tap_o = (f_d == '0);
  assign last_tap_o  = (f_d == F_LAST);
endmodule

// File: rtl/pe_conv_sequencer.sv
// Drives one SNN PE through a 1-D convolution pass: one command per (o, f),
// then a done token. All channel outputs come straight from registers.
module pe_conv_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH_F    = 3,
  parameter int DEPTH_I    = 5,
  parameter int ADDR_WIDTH = PE_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst,
  pe_conv_sequencer_if.master bus
);
  if (DEPTH_F < 1 || DEPTH_F > DEPTH_I || ADDR_WIDTH > PE_ADDR_WIDTH ||
      (ADDR_WIDTH < 31 && DEPTH_I > (1 << ADDR_WIDTH))) begin : g_param_err
    $error("pe_conv_sequencer: illegal DEPTH_F/DEPTH_I/ADDR_WIDTH combination");
  end

  seq_state_t state_q;
  pe_cmd_t    cmd_q;
  logic       cmd_valid_q;
  logic       done_valid_q;

  logic                  load, advance;
  logic [ADDR_WIDTH-1:0] o_nx, f_nx;
  logic                  first_nx, last_nx, last_cmd;

  assign load    = (state_q == SEQ_IDLE) && bus.start_valid && !bus.abort;
  assign advance = (state_q == SEQ_ISSUE) && bus.cmd_ready && !bus.abort;

  pe_tap_counter #(
    .DEPTH_F   (DEPTH_F),
    .DEPTH_I   (DEPTH_I),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_tap_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .advance_i  (advance),
    .clear_i    (bus.abort),
    .o_o        (o_nx),
    .f_o        (f_nx),
    .first_tap_o(first_nx),
    .last_tap_o (last_nx),
    .last_cmd_o (last_cmd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEQ_IDLE;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (load) begin
            state_q     <= SEQ_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_q       <= '{filter_addr: PE_ADDR_WIDTH'(f_nx),
                             ifmap_addr:  PE_ADDR_WIDTH'(o_nx + f_nx),
                             add_sel:     first_nx,
                             split_sel:   last_nx,
                             acc_clear:   last_nx};
          end
        end
        SEQ_ISSUE: begin
          if (bus.abort) begin
            state_q     <= SEQ_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
          end else if (bus.cmd_ready) begin
            if (last_cmd) begin
              state_q      <= SEQ_DONE;
              cmd_valid_q  <= 1'b0;
              done_valid_q <= 1'b1;
            end else begin
              cmd_q <= '{filter_addr: PE_ADDR_WIDTH'(f_nx),
                         ifmap_addr:  PE_ADDR_WIDTH'(o_nx + f_nx),
                         add_sel:     first_nx,
                         split_sel:   last_nx,
                         acc_clear:   last_nx};
            end
          end
        end
        SEQ_DONE: begin
          if (bus.abort || bus.done_ready) begin
            state_q      <= SEQ_IDLE;
            done_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= SEQ_IDLE;
          cmd_valid_q  <= 1'b0;
          done_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready     = (state_q == SEQ_IDLE);
  assign bus.busy            = (state_q != SEQ_IDLE);
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_filter_addr = cmd_q.filter_addr[ADDR_WIDTH-1:0];
  assign bus.cmd_ifmap_addr  = cmd_q.ifmap_addr[ADDR_WIDTH-1:0];
  assign bus.cmd_add_sel     = cmd_q.add_sel;
  assign bus.cmd_split_sel   = cmd_q.split_sel;
  assign bus.cmd_acc_clear   = cmd_q.acc_clear;
  assign bus.done_valid      = done_valid_q;
endmodule
